payment_controller: RTL and testbench
=====================================

Name: payment_controller

Overview:
- Consumer end of the product-price interface driven by product_selection: takes selected_price (0 = no product; A=15, B=20, C=25) plus coin inputs.
- Accumulates credit and issues a one-cycle dispense pulse once credit covers the price.
- Returns change or a refund as a train of 5-unit coin pulses.
- Sits between the price decoder and the dispense/coin-return mechanics of the vending machine.

Parameters:
- TIMEOUT_CYCLES, 1000: cycles in COLLECT with no coin before an automatic refund; must be >= 2.
- CNT_W, 10: width of the timeout counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  system clock, all state changes on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- selected_price  input  5  price from product_selection; 0 = no selection
- coin_in  input  2  00 none, 01 = 5, 10 = 10, 11 = 20; one coin per cycle when nonzero
- cancel  input  1  level, sampled each cycle; requests a refund
- credit  output  6  current accumulated credit (registered)
- busy  output  1  high whenever state != IDLE
- dispense  output  1  one-cycle pulse: release product
- change_coin  output  1  one pulse per 5-unit coin returned
- coin_reject  output  1  registered one-cycle pulse: coin refused and passed straight to the return slot

Behaviour:
- Reset (reset=0, async):
  - state=IDLE; credit, latched price, and timeout counter = 0.
  - All outputs 0.
  - Credit held at reset is discarded with no refund, including when reset arrives mid-COLLECT/VEND/CHANGE.
- States: IDLE, COLLECT, VEND, CHANGE.
- Moore outputs: dispense = (state==VEND); change_coin = (state==CHANGE); busy = (state!=IDLE).
- IDLE:
  - coin_in!=0 and selected_price!=0 → latch price = selected_price, credit = coin value, timeout counter cleared.
  - Next state after that coin: VEND if coin >= price, else COLLECT.
  - coin_in!=0 with selected_price==0 → coin_reject pulse next cycle; stay IDLE.
  - cancel in IDLE is ignored.
- COLLECT:
  - The latched price is used; changes on selected_price are ignored until the next IDLE.
  - A coin adds to credit and clears the timeout counter; if credit+coin >= price, next state is VEND.
  - No coin → counter increments; at TIMEOUT_CYCLES-1 the next state is CHANGE (refund).
  - cancel=1 → CHANGE. A coin in the same cycle is still added, so the full credit is refunded.
  - cancel beats the price-reached condition when both occur in the same cycle.
- VEND (exactly one cycle):
  - dispense=1; at the exit edge credit -= price.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- CHANGE:
  - change_coin=1 each cycle; credit decrements by 5 at each edge.
  - When credit becomes 0 → IDLE.
  - A change of N units gives N/5 consecutive pulses.
- Coins arriving in VEND or CHANGE are refused: coin_reject pulses the next cycle and credit is unchanged.
- Arithmetic:
  - Maximum credit is 24+20 = 44, which fits 6 bits; no overflow is possible.
  - Prices and coins are multiples of 5, so credit is always a multiple of 5.
  - If credit < 5 in CHANGE (a non-multiple price), credit is cleared and the state goes to IDLE, with no extra pulse.
- Latency:
  - Coin sampled at edge k → credit visible after edge k.
  - A dispense triggered by that coin is high in cycle k..k+1.
  - The first change_coin is in cycle k+1..k+2.

Test Plan:
- Price 15; coins 10, 10 → credit 10 then 20; dispense 1 cycle; 1 change_coin; credit 0; back to IDLE.
- Price 20; coins 10, 10 → dispense; no change_coin; IDLE one cycle after the dispense.
- Price 25; coin 20, then cancel with coin 5 in the same cycle → no dispense; 5 change_coin pulses; credit 25→0.
- selected_price=0, coin 10 → coin_reject pulse; credit stays 0; busy stays 0. Also: a coin during CHANGE → coin_reject, change count unaffected.
- TIMEOUT_CYCLES=8; price 25; single coin 10, then idle → refund starts 8 cycles after the coin; 2 change_coin pulses.
- Price 25, coins 20, 20 → CHANGE with credit 15. Assert reset=0 after the first change_coin → all outputs 0 immediately; state IDLE after release; no further pulses.

Source files
------------

// File: rtl/payment_controller.sv
// rtl/payment_controller.sv - vending payment controller: credit accumulation, dispense pulse, change/refund coin train
module payment_controller #(
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int CNT_W          = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] selected_price,
  input  logic [1:0] coin_in,
  input  logic       cancel,
  output logic [5:0] credit,
  output logic       busy,
  output logic       dispense,
  output logic       change_coin,
  output logic       coin_reject
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_e;

  state_e           state_q, state_d;
  logic [5:0]       credit_q, credit_d;
  logic [4:0]       price_q, price_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             reject_q, reject_d;

  logic [5:0] coin_val;
  logic [5:0] sum;
  logic       coin_present;

  always_comb begin
    case (coin_in)
      2'b01:   coin_val = 6'd5;
      2'b10:   coin_val = 6'd10;
      2'b11:   coin_val = 6'd20;
      default: coin_val = 6'd0;
    endcase
  end

  assign coin_present = (coin_in != 2'b00);
  assign sum          = credit_q + coin_val;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      price_q  <= '0;
      cnt_q    <= '0;
      reject_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      price_q  <= price_d;
      cnt_q    <= cnt_d;
      reject_q <= reject_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    price_d  = price_q;
    cnt_d    = cnt_q;
    reject_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (coin_present && selected_price != 5'd0) begin
          price_d  = selected_price;
          credit_d = coin_val;
          cnt_d    = '0;
          state_d  = (coin_val >= {1'b0, selected_price}) ? VEND : COLLECT;
        end else if (coin_present) begin
          reject_d = 1'b1;
        end
      end
      COLLECT: begin
        if (coin_present) begin
          credit_d = sum;
          cnt_d    = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
        // Cancel wins over reaching the price; any coin this cycle is already folded into the refund.
        if (cancel) begin
          state_d = CHANGE;
        end else if (coin_present && sum >= {1'b0, price_q}) begin
          state_d = VEND;
        end else if (!coin_present && cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = CHANGE;
        end
      end
      VEND: begin
        reject_d = coin_present;
        credit_d = credit_q - {1'b0, price_q};
        state_d  = (credit_q > {1'b0, price_q}) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_d = coin_present;
        if (credit_q <= 6'd5) begin
          credit_d = '0;
          state_d  = IDLE;
        end else begin
          credit_d = credit_q - 6'd5;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign credit      = credit_q;
  assign busy        = (state_q != IDLE);
  assign dispense    = (state_q == VEND);
  assign change_coin = (state_q == CHANGE);
  assign coin_reject = reject_q;

endmodule

// File: tb/tb_payment_controller.sv
// tb/tb_payment_controller.sv - randomized transaction-level check of payment_controller plus directed corner cases
module tb_payment_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] selected_price;
  logic [1:0] coin_in;
  logic       cancel;
  logic [5:0] credit;
  logic       busy, dispense, change_coin, coin_reject;

  int total = 0;
  int bad   = 0;
  int n_disp = 0, n_chg = 0, n_rej = 0;

  always #5 clk = ~clk;

  payment_controller #(.TIMEOUT_CYCLES(8), .CNT_W(10)) dut (
    .clk(clk), .reset(reset), .selected_price(selected_price), .coin_in(coin_in),
    .cancel(cancel), .credit(credit), .busy(busy), .dispense(dispense),
    .change_coin(change_coin), .coin_reject(coin_reject)
  );

  always @(negedge clk) begin
    if (dispense)    n_disp++;
    if (change_coin) n_chg++;
    if (coin_reject) n_rej++;
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int cval(input logic [1:0] code);
    case (code)
      2'b01:   return 5;
      2'b10:   return 10;
      2'b11:   return 20;
      default: return 0;
    endcase
  endfunction

  task automatic clr();
    n_disp = 0; n_chg = 0; n_rej = 0;
  endtask

  task automatic coin_cycle(input logic [1:0] code, input logic canc);
    coin_in = code; cancel = canc;
    @(negedge clk);
    coin_in = 2'b00; cancel = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    if (busy) check("idle_bound", 1, 0);
  endtask

  task automatic rand_txn();
    int price, sum, n, cidx, gap;
    logic [1:0] code;
    logic c;
    bit vend, canc;
    price = 15 + 5 * $urandom_range(0, 2);
    selected_price = 5'(price);
    clr();
    sum = 0; n = 0; vend = 0; canc = 0;
    cidx = $urandom_range(1, 6);
    while (!vend && !canc) begin
      code = 2'($urandom_range(1, 3));
      c = (n == cidx);
      coin_cycle(code, c);
      sum += cval(code);
      if (c) canc = 1;
      else if (sum >= price) vend = 1;
      check("rand_credit", credit, sum);
      if (n == 0) selected_price = 5'($urandom_range(1, 31));
      n++;
      if (!vend && !canc) begin
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
      end
    end
    wait_idle();
    check("rand_disp", n_disp, vend ? 1 : 0);
    check("rand_chg", n_chg, vend ? (sum - price) / 5 : sum / 5);
    check("rand_rej", n_rej, 0);
    check("rand_credit_end", credit, 0);
    selected_price = 5'd0;
  endtask

  initial begin
    int k;
    reset = 1'b0; selected_price = 5'd0; coin_in = 2'b00; cancel = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_outs", {dispense, change_coin, coin_reject}, 0);
    reset = 1'b1;
    @(negedge clk);

    // price 15, coins 10 + 10
    selected_price = 5'd15; clr();
    coin_cycle(2'b10, 1'b0);
    check("t1_credit10", credit, 10);
    coin_cycle(2'b10, 1'b0);
    check("t1_credit20", credit, 20);
    check("t1_disp", dispense, 1);
    @(negedge clk);
    check("t1_chg", change_coin, 1);
    check("t1_credit5", credit, 5);
    @(negedge clk);
    check("t1_idle", busy, 0);
    check("t1_credit0", credit, 0);
    check("t1_npulse", n_chg, 1);

    // price 20, exact payment
    selected_price = 5'd20; clr();
    coin_cycle(2'b10, 1'b0);
    coin_cycle(2'b10, 1'b0);
    check("t2_disp", dispense, 1);
    @(negedge clk);
    check("t2_idle", busy, 0);
    check("t2_nchg", n_chg, 0);

    // price 25, cancel with a coin; coin inserted during refund is rejected
    selected_price = 5'd25; clr();
    coin_cycle(2'b11, 1'b0);
    coin_cycle(2'b01, 1'b1);
    check("t3_credit25", credit, 25);
    check("t3_chg", change_coin, 1);
    coin_cycle(2'b10, 1'b0);
    check("t3_reject", coin_reject, 1);
    check("t3_credit20", credit, 20);
    wait_idle();
    check("t3_nchg", n_chg, 5);
    check("t3_ndisp", n_disp, 0);
    check("t3_nrej", n_rej, 1);

    // no selection: coin refused
    selected_price = 5'd0; clr();
    coin_cycle(2'b10, 1'b0);
    check("t4_reject", coin_reject, 1);
    check("t4_credit", credit, 0);
    check("t4_busy", busy, 0);
    @(negedge clk);
    check("t4_reject_end", coin_reject, 0);

    // cancel while idle does nothing
    coin_cycle(2'b00, 1'b1);
    check("t4_cancel_idle", busy, 0);

    // timeout refund
    selected_price = 5'd25; clr();
    coin_cycle(2'b10, 1'b0);
    check("t5_busy", busy, 1);
    k = 0;
    while (!change_coin && k < 30) begin
      @(negedge clk);
      k++;
    end
    check("t5_timeout_cycles", k, 8);
    wait_idle();
    check("t5_nchg", n_chg, 2);

    // reset in the middle of change return
    selected_price = 5'd25; clr();
    coin_cycle(2'b11, 1'b0);
    coin_cycle(2'b11, 1'b0);
    check("t6_disp", dispense, 1);
    @(negedge clk);
    check("t6_chg", change_coin, 1);
    check("t6_credit15", credit, 15);
    #1 reset = 1'b0;
    #1;
    check("t6_rst_credit", credit, 0);
    check("t6_rst_outs", {busy, dispense, change_coin, coin_reject}, 0);
    @(negedge clk);
    reset = 1'b1; clr();
    repeat (5) @(negedge clk);
    check("t6_no_pulse", n_chg, 0);
    check("t6_busy", busy, 0);

    selected_price = 5'd0;
    for (int i = 0; i < 40; i++) rand_txn();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
